mopshub_test_sequencer: RTL
===========================

# mopshub_test_sequencer

Test-phase scheduler for the MOPSHUB system bench, clocked on the master 40 MHz domain. On each start request it steps every CAN bus through an ordered set of test phases: oscillator trim, RX test, end-wait pulse plus settling gap, TX test, and custom message. It drives the data generator's phase-request inputs and waits for each phase's completion pulse. It replaces hand-written phase sequencing with a deterministic, per-bus FSM that has a watchdog.

## Interface
Parameters:
- N_BUSES, 5'd2, number of buses iterated (1..31); the bus index runs 0..N_BUSES-1.
- GAP_CYCLES, 16'd120, idle cycles between the end-wait pulse and the TX phase (3 µs at 40 MHz).
- ENDWAIT_CYCLES, 4'd1, width of the endwait_all pulse in cycles (≥1).
- TIMEOUT_CYCLES, 24'd400000, per-phase watchdog limit (used only when TB_SEQ_TIMEOUT_EN is defined).

Ports:
- clk_40_m  in  1  master 40 MHz clock. All logic is rising-edge.
- rst  in  1  reset: synchronous, active-low.
- start  in  1  start request (sign-on). Level-sampled in IDLE only.
- phase_mask  in  4  phase enables: [0] trim, [1] rx, [2] tx, [3] advanced. Captured when the sequence starts.
- trim_done  in  1  trim completion pulse.
- rx_end  in  1  RX-test completion pulse.
- tx_end  in  1  TX-test completion pulse.
- msg_end  in  1  custom-message completion pulse.
- osc_auto_trim  out  1  trim request level.
- test_rx  out  1  RX-test request level.
- test_tx  out  1  TX-test request level.
- test_advanced  out  1  custom-message request level.
- endwait_all  out  1  end-wait pulse.
- bus_cnt  out  5  current bus index.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when the sequence completes.
- timeout_err  out  1  sticky watchdog flag.
- err_info  out  8  {bus[4:0], phase[2:0]} of the first timeout.

## Operation
- States: IDLE, TRIM, RX, ENDWAIT, GAP, TX, ADV, NEXT, FIN.
- IDLE:
  - When start=1: capture phase_mask into mask_q, set bus_cnt=0, and go to the first enabled phase.
  - If mask_q==0, go to FIN.
- Phase order per bus: TRIM → RX → ENDWAIT → GAP → TX → ADV → NEXT.
  - Disabled phases are skipped in the same transition; there are no dead cycles.
  - ENDWAIT and GAP run only if RX is enabled.
- Request phases (TRIM, RX, TX, ADV):
  - The matching request output is high for the entire time the FSM is in that state.
  - The state exits when its own completion input is sampled high.
  - Completion inputs belonging to other phases are ignored.
- ENDWAIT holds endwait_all=1 for ENDWAIT_CYCLES cycles. GAP then counts GAP_CYCLES cycles with all requests low.
- NEXT:
  - If bus_cnt==N_BUSES-1, go to FIN.
  - Otherwise increment bus_cnt and go to the first enabled phase.
- FIN asserts done for one cycle, then returns to IDLE. bus_cnt holds its last value.
- start while busy=1 is ignored. A start level still high on the return to IDLE restarts the sequence.
- Phase codes for err_info: TRIM=1, RX=2, TX=3, ADV=4.
- Reset values (rst=0 at an edge): state IDLE, all outputs 0, counters 0, err_info 0, timeout_err 0.
  - Reset mid-phase drops every request on that edge.

## Timing
- All outputs are registered.
- The request goes high on the same edge that enters its state: one cycle after start is sampled, or one cycle after the previous phase's completion is sampled.
- The request goes low on the edge that samples completion. The next phase's request rises on that same edge.
- endwait_all rises on the edge after rx_end is sampled. It is high for exactly ENDWAIT_CYCLES cycles.
- The test_tx rise follows the endwait_all fall by exactly GAP_CYCLES cycles.
- The phase counter clears on every state change. Counter widths saturate; there is no wrap-around.
- done is high in the cycle after NEXT or after an empty mask.

## Configuration
- Macro TB_SEQ_TIMEOUT_EN.
- Defined:
  - Each request phase counts cycles. When the count reaches TIMEOUT_CYCLES, the request drops, timeout_err sets (sticky until reset), and the FSM advances as if completion had occurred.
  - err_info latches the first offending bus and phase; later timeouts do not overwrite it.
- Undefined:
  - No watchdog; phases wait indefinitely.
  - timeout_err and err_info are constant 0.

## Test plan
- Full run: phase_mask=4'hF, N_BUSES=2, completion pulses 10 cycles after each request.
  - Required order per bus: trim, rx, endwait (1 cycle), 120-cycle gap, tx, adv.
  - bus_cnt goes 0 then 1; a single done pulse; busy falls on the same edge done falls.
- Masked run: phase_mask=4'b0100 (TX only).
  - Only test_tx toggles, once per bus.
  - endwait_all never asserts.
  - done 1 cycle after the second tx_end.
- Empty mask: phase_mask=0 with start.
  - done pulses on the second edge after start; no request is ever raised.
- Spurious completions: tx_end pulsed during RX.
  - RX is held and the FSM stays in RX until rx_end arrives.
- Reset mid-phase: rst=0 during TX.
  - All outputs are 0 on the next edge.
  - After release with start=0, the FSM stays IDLE.
- Watchdog (TB_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50): never pulse rx_end on bus 1.
  - test_rx drops after 50 cycles; timeout_err=1; err_info=8'h0A; the sequence completes with done.

Source files
------------

// File: rtl/mopshub_test_sequencer.sv
// Per-bus test-phase scheduler: trim, RX, end-wait pulse + settling gap, TX, custom message.
// Define TB_SEQ_TIMEOUT_EN to enable the per-phase watchdog (timeout_err / err_info).
module mopshub_test_sequencer #(
    parameter logic [4:0]  N_BUSES        = 5'd2,
    parameter logic [15:0] GAP_CYCLES     = 16'd120,
    parameter logic [3:0]  ENDWAIT_CYCLES = 4'd1,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd400000
) (
    input  logic       clk_40_m,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] phase_mask,
    input  logic       trim_done,
    input  logic       rx_end,
    input  logic       tx_end,
    input  logic       msg_end,
    output logic       osc_auto_trim,
    output logic       test_rx,
    output logic       test_tx,
    output logic       test_advanced,
    output logic       endwait_all,
    output logic [4:0] bus_cnt,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic [7:0] err_info,
    output logic [3:0] dbg_state_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_TRIM    = 4'd1,
        S_RX      = 4'd2,
        S_ENDWAIT = 4'd3,
        S_GAP     = 4'd4,
        S_TX      = 4'd5,
        S_ADV     = 4'd6,
        S_NEXT    = 4'd7,
        S_FIN     = 4'd8
    } state_e;

`ifdef TB_SEQ_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [4:0]  bus_q, bus_d;
    logic [23:0] cnt_q, cnt_d;
    logic [24:0] cnt_p1;
    logic        timeout_q;
    logic [7:0]  err_q;
    logic        is_req, own_done, wd_hit, phase_exit;
    logic [2:0]  phase_code;

    // First enabled phase at or after position 'from' (0=trim, 1=rx, 2=tx, 3=adv).
    function automatic state_e pick(input logic [3:0] m, input logic [1:0] from);
        state_e s;
        s = S_NEXT;
        if (m[3]) s = S_ADV;
        if (m[2] && from <= 2'd2) s = S_TX;
        if (m[1] && from <= 2'd1) s = S_RX;
        if (m[0] && from == 2'd0) s = S_TRIM;
        return s;
    endfunction

    assign cnt_p1 = {1'b0, cnt_q} + 25'd1;

    always_comb begin
        is_req     = 1'b0;
        own_done   = 1'b0;
        phase_code = 3'd0;
        case (state_q)
            S_TRIM: begin is_req = 1'b1; own_done = trim_done; phase_code = 3'd1; end
            S_RX:   begin is_req = 1'b1; own_done = rx_end;    phase_code = 3'd2; end
            S_TX:   begin is_req = 1'b1; own_done = tx_end;    phase_code = 3'd3; end
            S_ADV:  begin is_req = 1'b1; own_done = msg_end;   phase_code = 3'd4; end
            default: ;
        endcase
        wd_hit     = WD_EN && is_req && !own_done && (cnt_p1 >= {1'b0, TIMEOUT_CYCLES});
        phase_exit = own_done || wd_hit;
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        bus_d   = bus_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = phase_mask;
                    bus_d   = 5'd0;
                    state_d = pick(phase_mask, 2'd0);
                end
            end
            S_TRIM:    if (phase_exit) state_d = pick(mask_q, 2'd1);
            S_RX:      if (phase_exit) state_d = S_ENDWAIT;
            S_ENDWAIT: begin
                if (cnt_p1 >= {21'd0, ENDWAIT_CYCLES})
                    state_d = (GAP_CYCLES == 16'd0) ? pick(mask_q, 2'd2) : S_GAP;
            end
            S_GAP:     if (cnt_p1 >= {9'd0, GAP_CYCLES}) state_d = pick(mask_q, 2'd2);
            S_TX:      if (phase_exit) state_d = pick(mask_q, 2'd3);
            S_ADV:     if (phase_exit) state_d = S_NEXT;
            S_NEXT: begin
                // An empty mask also passes through here so done lands one cycle later.
                if (mask_q == 4'd0 || bus_q >= N_BUSES - 5'd1) begin
                    state_d = S_FIN;
                end else begin
                    bus_d   = bus_q + 5'd1;
                    state_d = pick(mask_q, 2'd0);
                end
            end
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = 24'd0;
        else if (&cnt_q)        cnt_d = cnt_q;
        else                    cnt_d = cnt_q + 24'd1;
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            mask_q        <= 4'd0;
            bus_q         <= 5'd0;
            cnt_q         <= 24'd0;
            timeout_q     <= 1'b0;
            err_q         <= 8'd0;
            osc_auto_trim <= 1'b0;
            test_rx       <= 1'b0;
            test_tx       <= 1'b0;
            test_advanced <= 1'b0;
            endwait_all   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            bus_q         <= bus_d;
            cnt_q         <= cnt_d;
            osc_auto_trim <= (state_d == S_TRIM);
            test_rx       <= (state_d == S_RX);
            test_tx       <= (state_d == S_TX);
            test_advanced <= (state_d == S_ADV);
            endwait_all   <= (state_d == S_ENDWAIT);
            busy          <= (state_d != S_IDLE);
            done          <= (state_d == S_FIN);
            if (wd_hit) begin
                timeout_q <= 1'b1;
                if (!timeout_q) err_q <= {bus_q, phase_code};
            end
        end
    end

    assign bus_cnt     = bus_q;
    assign timeout_err = timeout_q;
    assign err_info    = err_q;
    assign dbg_state_o = state_q;

endmodule
